// File: rtl/adc_serial_rx.sv
// adc_serial_rx: serial ADC receiver feeding the IIR biquad datapath.
// Paces conversions at a fixed sample rate, clocks a 16-bit frame out of a
// 12-bit SPI-style ADC, converts the offset-binary code to signed Q(p).(f)
// and strobes `enable` once per completed frame.
//
// Ports:
//   sclk       system clock, rising edge
//   rst        asynchronous active-low reset
//   adc_sdata  ADC serial data in
//   adc_cs_n   ADC chip select (active-low)
//   adc_sck    ADC serial clock, idles high
//   uk         signed Q(p).(f) sample, held between strobes
//   enable     1-cycle strobe, uk new in the same cycle
//   busy       frame in progress
//   fmt_err    1-cycle pulse with enable when a leading frame bit was 1
//   overrun    1-cycle pulse when a sample tick lands while busy
module adc_serial_rx #(
    parameter  int unsigned p             = 8,
    parameter  int unsigned f             = 14,
    parameter  int unsigned ADC_BITS      = 12,
    parameter  int unsigned CLK_DIV       = 4,
    parameter  int unsigned SAMPLE_PERIOD = 500,
    localparam int unsigned Width         = 1 + p + f
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             adc_sdata,
    output logic             adc_cs_n,
    output logic             adc_sck,
    output logic [Width-1:0] uk,
    output logic             enable,
    output logic             busy,
    output logic             fmt_err,
    output logic             overrun
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned SHIFT_AMT  = f - (ADC_BITS - 1);
    localparam int unsigned DIV_W      = $clog2(2 * CLK_DIV);
    localparam int unsigned TICK_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned BIT_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    state_t                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q;
    logic                    tick_c;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    cs_n_d, sck_d, busy_d, enable_d, fmt_err_d;
    logic [Width-1:0]        uk_d;
    logic signed [ADC_BITS-1:0] samp_c;
    logic signed [Width-1:0] ext_c;

    // Free-running sample-rate counter; tick marks the wrap to zero.
    assign tick_c = (tick_q == TICK_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            tick_q  <= '0;
            overrun <= 1'b0;
        end else begin
            tick_q  <= tick_c ? '0 : tick_q + TICK_W'(1);
            overrun <= tick_c && (state_q != IDLE);
        end
    end

    // Offset binary to two's complement is an MSB flip, then scale to Q(p).(f).
    always_comb begin
        samp_c = {~shift_q[ADC_BITS-1], shift_q[ADC_BITS-2:0]};
        ext_c  = Width'(samp_c);
    end

    // State and registered outputs.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            adc_cs_n <= 1'b1;
            adc_sck  <= 1'b1;
            busy     <= 1'b0;
            enable   <= 1'b0;
            fmt_err  <= 1'b0;
            uk       <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            adc_cs_n <= cs_n_d;
            adc_sck  <= sck_d;
            busy     <= busy_d;
            enable   <= enable_d;
            fmt_err  <= fmt_err_d;
            uk       <= uk_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        cs_n_d    = adc_cs_n;
        sck_d     = adc_sck;
        busy_d    = busy;
        uk_d      = uk;
        enable_d  = 1'b0;
        fmt_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick_c) begin
                    state_d = START;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end
            START: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    sck_d   = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q != DIV_W'(CLK_DIV - 1)) begin
                    div_d = div_q + DIV_W'(1);
                end else if (adc_sck && (bit_q == BIT_W'(FRAME_BITS))) begin
                    // High half of the 16th period finished: frame complete.
                    state_d   = DONE;
                    div_d     = '0;
                    cs_n_d    = 1'b1;
                    sck_d     = 1'b1;
                    enable_d  = 1'b1;
                    fmt_err_d = |shift_q[FRAME_BITS-1:ADC_BITS];
                    uk_d      = ext_c <<< SHIFT_AMT;
                end else begin
                    div_d = '0;
                    sck_d = ~adc_sck;
                    // Capture on the cycle where sck goes 0->1.
                    if (!adc_sck) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], adc_sdata};
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = QUIET;
                div_d   = '0;
            end
            QUIET: begin
                if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: two instances (SAMPLE_PERIOD 100 and 40, CLK_DIV 2)
// each talking to a behavioural ADC that serves directed and random frames.
module tb_adc_serial_rx;

    localparam int unsigned W      = 23;
    localparam int unsigned CD     = 2;
    localparam int unsigned FL     = 35 * CD + 1;
    localparam int unsigned RUN    = 2000;

    logic        sclk = 1'b0;
    logic        rst  = 1'b0;
    logic        sdata   [2];
    logic        cs_n_w  [2];
    logic        sck_w   [2];
    logic [W-1:0] uk_w   [2];
    logic        en_w    [2];
    logic        busy_w  [2];
    logic        fmt_w   [2];
    logic        ovr_w   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 sclk = ~sclk;

    adc_serial_rx #(.p(8), .f(14), .ADC_BITS(12), .CLK_DIV(CD), .SAMPLE_PERIOD(100)) u_dut0 (
        .sclk(sclk), .rst(rst), .adc_sdata(sdata[0]), .adc_cs_n(cs_n_w[0]),
        .adc_sck(sck_w[0]), .uk(uk_w[0]), .enable(en_w[0]), .busy(busy_w[0]),
        .fmt_err(fmt_w[0]), .overrun(ovr_w[0]));

    adc_serial_rx #(.p(8), .f(14), .ADC_BITS(12), .CLK_DIV(CD), .SAMPLE_PERIOD(40)) u_dut1 (
        .sclk(sclk), .rst(rst), .adc_sdata(sdata[1]), .adc_cs_n(cs_n_w[1]),
        .adc_sck(sck_w[1]), .uk(uk_w[1]), .enable(en_w[1]), .busy(busy_w[1]),
        .fmt_err(fmt_w[1]), .overrun(ovr_w[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference conversion: signed offset from mid-scale, scaled by 2^(f-11).
    function automatic logic [W-1:0] ref_uk(input logic [15:0] fr);
        int s;
        s = int'(fr[11:0]) - 2048;
        return W'(s * 8);
    endfunction

    function automatic int sp_of(input int g);
        return (g == 0) ? 100 : 40;
    endfunction

    // Distance between accepted ticks: first multiple of SP after the frame ends.
    function automatic int interval_of(input int g);
        int i;
        i = sp_of(g);
        while (i < int'(FL) + 1) i += sp_of(g);
        return i;
    endfunction

    // Directed frames served first to instance 0, with hand-computed results.
    logic [15:0] dir_fr  [5] = '{16'h0800, 16'h0FFF, 16'h0000, 16'h0801, 16'hF123};
    logic [W-1:0] dir_uk [5] = '{23'h000000, 23'h003FF8, 23'h7FC000, 23'h000008, 23'h7FC918};
    logic        dir_fmt [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int dir_idx = 0;

    int          cyc;
    logic [23:0] exp_q [2][$];
    logic [15:0] cur   [2];
    int          rises [2];
    int          bitpos[2];
    int          last_fall[2];
    bit          first [2];
    int          en_since[2];
    int          ovr_since[2];
    int          en_cnt[2];
    logic        prev_cs[2], prev_sck[2], prev_en[2], prev_ovr[2];
    logic [23:0] ent;
    logic [15:0] fr;

    always @(posedge sclk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // ADC model plus monitor, sampled mid-cycle on the falling edge.
    always @(negedge sclk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                exp_q[g].delete();
                rises[g] = 0; bitpos[g] = 15; sdata[g] = 1'b0;
                last_fall[g] = 0; first[g] = 1'b1;
                en_since[g] = 0; ovr_since[g] = 0; en_cnt[g] = 0;
                prev_cs[g] = 1'b1; prev_sck[g] = 1'b1; prev_en[g] = 1'b0; prev_ovr[g] = 1'b0;
            end else begin
                if (ovr_w[g]) begin
                    ovr_since[g]++;
                    check($sformatf("overrun_width%0d", g), 32'(prev_ovr[g]), 0);
                end
                if (fmt_w[g]) check($sformatf("fmt_with_enable%0d", g), 32'(en_w[g]), 1);
                if (en_w[g]) begin
                    en_since[g]++;
                    en_cnt[g]++;
                    check($sformatf("enable_width%0d", g), 32'(prev_en[g]), 0);
                    check($sformatf("sck_rises%0d", g), rises[g], 16);
                    check($sformatf("idle_lines%0d", g), {cs_n_w[g], sck_w[g]}, 2'b11);
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("enable_spurious%0d", g), 1, 0);
                    end else begin
                        ent = exp_q[g].pop_front();
                        check($sformatf("uk%0d", g), 32'(uk_w[g]), 32'(ent[W-1:0]));
                        check($sformatf("fmt_err%0d", g), 32'(fmt_w[g]), 32'(ent[23]));
                    end
                end
                if (prev_cs[g] && !cs_n_w[g]) begin
                    check($sformatf("start_interval%0d", g), cyc - last_fall[g],
                          first[g] ? sp_of(g) : interval_of(g));
                    check($sformatf("enables_per_frame%0d", g), en_since[g], first[g] ? 0 : 1);
                    check($sformatf("overruns_per_frame%0d", g), ovr_since[g],
                          first[g] ? 0 : interval_of(g) / sp_of(g) - 1);
                    last_fall[g] = cyc; first[g] = 1'b0;
                    en_since[g] = 0; ovr_since[g] = 0; rises[g] = 0;
                    if (g == 0 && dir_idx < 5) begin
                        fr  = dir_fr[dir_idx];
                        ent = {dir_fmt[dir_idx], dir_uk[dir_idx]};
                        dir_idx++;
                    end else begin
                        fr[11:0]  = 12'($urandom);
                        fr[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
                        ent = {(fr[15:12] != 4'h0), ref_uk(fr)};
                    end
                    cur[g] = fr;
                    exp_q[g].push_back(ent);
                    bitpos[g] = 15;
                    sdata[g]  = fr[15];
                end else if (!cs_n_w[g]) begin
                    if (!prev_sck[g] && sck_w[g]) rises[g]++;
                    // Next bit appears on each falling sck after the first rise.
                    if (prev_sck[g] && !sck_w[g] && rises[g] > 0 && bitpos[g] > 0) begin
                        bitpos[g]--;
                        sdata[g] = cur[g][bitpos[g]];
                    end
                end
                prev_cs[g]  = cs_n_w[g];
                prev_sck[g] = sck_w[g];
                prev_en[g]  = en_w[g];
                prev_ovr[g] = ovr_w[g];
            end
        end
    end

    initial begin
        int t;
        int s;
        int n_exp;

        repeat (3) @(negedge sclk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_cs_n%0d", g), 32'(cs_n_w[g]), 1);
            check($sformatf("rst_sck%0d", g), 32'(sck_w[g]), 1);
            check($sformatf("rst_uk%0d", g), 32'(uk_w[g]), 0);
            check($sformatf("rst_enable%0d", g), 32'(en_w[g]), 0);
            check($sformatf("rst_busy%0d", g), 32'(busy_w[g]), 0);
            check($sformatf("rst_fmt%0d", g), 32'(fmt_w[g]), 0);
            check($sformatf("rst_overrun%0d", g), 32'(ovr_w[g]), 0);
        end
        rst = 1'b1;

        // Run six frames on instance 0, then hit reset in the 7th sck period of the next.
        t = 0;
        while (!(en_cnt[0] >= 6 && rises[0] == 6 && !sck_w[0] && !cs_n_w[0]) && t < 20000) begin
            @(posedge sclk);
            #2;
            t++;
        end
        check("reset_wait_timeout", 32'(t < 20000), 1);
        #1 rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("abort_cs_n%0d", g), 32'(cs_n_w[g]), 1);
            check($sformatf("abort_sck%0d", g), 32'(sck_w[g]), 1);
            check($sformatf("abort_enable%0d", g), 32'(en_w[g]), 0);
            check($sformatf("abort_busy%0d", g), 32'(busy_w[g]), 0);
            check($sformatf("abort_uk%0d", g), 32'(uk_w[g]), 0);
        end
        repeat (3) @(negedge sclk);
        rst = 1'b1;

        repeat (RUN) @(posedge sclk);
        @(negedge sclk);
        #1;
        for (int g = 0; g < 2; g++) begin
            n_exp = 0;
            s = sp_of(g);
            while (s + 33 * int'(CD) <= int'(RUN)) begin
                n_exp++;
                s += interval_of(g);
            end
            check($sformatf("enable_count%0d", g), en_cnt[g], n_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
